// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_queue
//  Purpose  : Instruction-fetch front end. Owns the fetch PC, issues one
//             outstanding req/ack memory fetch at a time, buffers returned
//             words in a DEPTH-entry FIFO and hands {pc, instr} to decode.
//             Define IFETCH_PERF_EN to add fetched/dropped word counters.
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_fpc;
    logic [31:0]          r_addr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [31:0]          r_pc_mem    [DEPTH];
    logic [31:0]          r_instr_mem [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_unused;

    assign w_push   = (r_state == REQ) && imem_ack && !redirect_valid;
    assign w_pop    = (r_count != '0) && id_ready;
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    assign imem_req  = (r_state != IDLE);
    assign imem_addr = r_addr;
    assign id_valid  = (r_count != '0);
    assign id_pc     = id_valid ? r_pc_mem[r_rd_ptr]    : 32'd0;
    assign id_instr  = id_valid ? r_instr_mem[r_rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_fpc    <= RESET_PC;
            r_addr   <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((r_count < c_depth) && !redirect_valid) begin
                        r_addr  <= r_fpc;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        r_state <= IDLE;
                        if (!redirect_valid)
                            r_fpc <= r_fpc + 32'd4;
                    end else if (redirect_valid) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // A redirect wins over any push/pop on the same edge.
            if (redirect_valid) begin
                r_fpc    <= {redirect_pc[31:2], 2'b00};
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_w'(1);
                    2'b01:   r_count <= r_count - c_cnt_w'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_addr;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end

`ifdef IFETCH_PERF_EN
    logic        w_drop_ack;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;

    assign w_drop_ack = imem_ack &&
                        (((r_state == REQ) && redirect_valid) || (r_state == DROP));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= 32'd0;
            r_perf_dropped <= 32'd0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_push);
            r_perf_dropped <= r_perf_dropped + 32'(w_drop_ack)
                            + (redirect_valid ? 32'(r_count) : 32'd0);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
`else
    // Counters absent; fetch and flush behaviour is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_queue
//  Purpose  : Directed and randomized bench for ifetch_queue against a
//             queue-based reference model and a variable-latency memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    ifetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: delivered words in fetch order, one outstanding fetch.
    logic [63:0]  mq[$];
    logic [31:0]  m_fpc = 32'h3000;
    logic [31:0]  m_addr = 32'h3000;
    bit           m_req = 1'b0;
    bit           m_wrong = 1'b0;
    logic [31:0]  m_fetched = 32'd0;
    logic [31:0]  m_dropped = 32'd0;
    int unsigned  mem_wait = 0;
    int unsigned  mem_lat = 0;
    int unsigned  lat_min = 0;
    int unsigned  lat_max = 0;
    int           popped = 0;
    logic [31:0]  seen[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
        chk("imem_addr", imem_addr, m_addr);
        chk("id_valid", {31'd0, id_valid}, {31'd0, mq.size() != 0});
        chk("id_pc", id_pc, (mq.size() != 0) ? mq[0][63:32] : 32'd0);
        chk("id_instr", id_instr, (mq.size() != 0) ? mq[0][31:0] : 32'd0);
`ifdef IFETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_dropped", perf_dropped, m_dropped);
`endif
    endtask

    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        logic        ack;
        logic [31:0] rd;
        int          n;
        bit          issue;
        bit          push;
        ack = m_req && (mem_wait >= mem_lat);
        rd  = ack ? mem_word(m_addr) : $urandom();
        rst = r; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        imem_ack = ack; imem_rdata = rd;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_fpc = 32'h3000; m_addr = 32'h3000; m_req = 1'b0; m_wrong = 1'b0;
            m_fetched = 32'd0; m_dropped = 32'd0;
        end else begin
            n     = mq.size();
            issue = !m_req && (n < 4) && !rv;
            push  = 1'b0;
            if (m_req && ack) begin
                if (m_wrong || rv) m_dropped++;
                else push = 1'b1;
                m_req = 1'b0; m_wrong = 1'b0;
            end else if (m_req && rv) begin
                m_wrong = 1'b1;
            end
            if (rv) begin
                m_dropped += 32'(n);
                mq.delete();
                m_fpc = {rpc[31:2], 2'b00};
            end else begin
                if (rdy && n != 0) void'(mq.pop_front());
                if (push) begin
                    mq.push_back({m_addr, rd});
                    m_fpc += 32'd4;
                    m_fetched++;
                end
            end
            if (issue) begin
                m_req = 1'b1; m_addr = m_fpc; m_wrong = 1'b0;
                mem_wait = 0; mem_lat = $urandom_range(lat_max, lat_min);
            end else if (m_req) begin
                mem_wait++;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        lat_min = 0; lat_max = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Zero-wait streaming: addresses 0x3000, 0x3004, 0x3008 in order
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0);
            if (imem_req && (seen.size() == 0 || seen[$] !== imem_addr)) seen.push_back(imem_addr);
        end
        chk("stream_addr0", (seen.size() > 0) ? seen[0] : 32'hX, 32'h3000);
        chk("stream_addr1", (seen.size() > 1) ? seen[1] : 32'hX, 32'h3004);
        chk("stream_addr2", (seen.size() > 2) ? seen[2] : 32'hX, 32'h3008);

        // Back-pressure: fill four entries, then a single pop reissues 0x3010
        step(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 0);
        chk("full_req_idle", {31'd0, imem_req}, 32'd0);
        chk("full_head_pc", id_pc, 32'h3000);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("refill_req", {31'd0, imem_req}, 32'd1);
        chk("refill_addr", imem_addr, 32'h3010);

        // Redirect to 0x4002 with three queued entries
        step(0, 0, 1, 32'h0000_4002);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        step(0, 1, 0, 0);
        chk("redir_addr", imem_addr, 32'h4000);
        for (int i = 0; i < 10 && !id_valid; i++) step(0, 1, 0, 0);
        chk("redir_first_pc", id_pc, 32'h4000);

        // Redirect during a 3-cycle-latency fetch of 0x3008
        step(1, 0, 0, 0);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 60 && !(m_req && m_addr == 32'h3008 && mem_wait == 0); i++)
            step(0, 1, 0, 0);
        step(0, 1, 1, 32'h0000_5000);
        chk("drop_req_held", {31'd0, imem_req}, 32'd1);
        chk("drop_addr_held", imem_addr, 32'h3008);
        for (int i = 0; i < 12 && !(m_req && m_addr == 32'h5000); i++) step(0, 1, 0, 0);
        chk("drop_next_addr", imem_addr, 32'h5000);

        // Redirect, pop and ack on the same edge
        step(1, 0, 0, 0);
        lat_min = 0; lat_max = 0;
        for (int i = 0; i < 20 && !(m_req && mq.size() > 0); i++) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_6004);
        chk("triple_empty", {31'd0, id_valid}, 32'd0);
        step(0, 1, 0, 0);
        chk("triple_target", imem_addr, 32'h6004);

        // Five fetched, two queued plus one in flight, then redirect
        step(1, 0, 0, 0);
        lat_min = 2; lat_max = 2; popped = 0;
        for (int i = 0; i < 80 && !(m_fetched == 5 && m_req && mq.size() == 2); i++) begin
            if (popped < 3 && mq.size() > 0) popped++;
            step(0, popped < 3 || mq.size() == 0 ? (popped <= 3) : 1'b0, 0, 0);
        end
        step(0, 0, 1, 32'h0000_7000);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
`ifdef IFETCH_PERF_EN
        chk("perf_fetched5", perf_fetched, 32'd5);
        chk("perf_dropped3", perf_dropped, 32'd3);
`endif

        // Randomized traffic
        step(1, 0, 0, 0);
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 600; i++)
            step(($urandom_range(99, 0) == 0), 1'($urandom_range(1, 0)),
                 ($urandom_range(9, 0) == 0), $urandom());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
